// File: rtl/ctrlport_if.sv
// Control-port bundle: request fields from master to slave, response fields back.
interface ctrlport_if;
  logic        req_wr;
  logic        req_rd;
  logic [19:0] req_addr;
  logic [9:0]  req_portid;
  logic [31:0] req_data;
  logic [3:0]  req_byte_en;
  logic        req_has_time;
  logic [63:0] req_time;
  logic        resp_ack;
  logic [1:0]  resp_status;
  logic [31:0] resp_data;

  modport master (
    output req_wr, req_rd, req_addr, req_portid, req_data, req_byte_en, req_has_time, req_time,
    input  resp_ack, resp_status, resp_data
  );
  modport slave (
    input  req_wr, req_rd, req_addr, req_portid, req_data, req_byte_en, req_has_time, req_time,
    output resp_ack, resp_status, resp_data
  );
endinterface

// File: rtl/ctrlport_if_resp_timeout.sv
// Inline responder guard: forwards one ctrlport request at a time and synthesizes
// a CMDERR ack when the downstream target stays silent for TIMEOUT cycles.
module ctrlport_if_resp_timeout #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             ctrlport_clk,
  input  logic             ctrlport_rst,
  ctrlport_if.slave        s_ctrlport,
  ctrlport_if.master       m_ctrlport,
  output logic             busy,
  output logic [CNT_W-1:0] timeout_count,
  output logic             req_dropped
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
  localparam logic [1:0] ST_CMDERR = 2'b01;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t            state_r, state_next_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_next_s;
  logic              req_s, ack_hit_s, timeout_hit_s;
  logic              resp_ack_r;
  logic [1:0]        resp_status_r;
  logic [31:0]       resp_data_r;

  assign req_s = s_ctrlport.req_wr | s_ctrlport.req_rd;

  // State and wait-counter register
  always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
    if (ctrlport_rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Next-state logic; the counter holds k during the k-th WAIT cycle
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_next_s    = ST_WAIT;
          wait_cnt_next_s = WAIT_W'(1);
        end else begin
          wait_cnt_next_s = '0;
        end
      end
      ST_WAIT: begin
        if (m_ctrlport.resp_ack || (wait_cnt_r == TIMEOUT_V)) begin
          state_next_s    = ST_IDLE;
          wait_cnt_next_s = '0;
        end else begin
          wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        wait_cnt_next_s = '0;
      end
    endcase
  end

  // Output decode; a real ack on the last WAIT cycle beats the timeout
  always_comb begin
    ack_hit_s     = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ack_hit_s     = 1'b0;
        timeout_hit_s = 1'b0;
      end
      ST_WAIT: begin
        ack_hit_s     = m_ctrlport.resp_ack;
        timeout_hit_s = !m_ctrlport.resp_ack && (wait_cnt_r == TIMEOUT_V);
      end
      default: begin
        ack_hit_s     = 1'b0;
        timeout_hit_s = 1'b0;
      end
    endcase
  end

  assign m_ctrlport.req_wr       = (state_r == ST_IDLE) ? s_ctrlport.req_wr : 1'b0;
  assign m_ctrlport.req_rd       = (state_r == ST_IDLE) ? s_ctrlport.req_rd : 1'b0;
  assign m_ctrlport.req_addr     = s_ctrlport.req_addr;
  assign m_ctrlport.req_portid   = s_ctrlport.req_portid;
  assign m_ctrlport.req_data     = s_ctrlport.req_data;
  assign m_ctrlport.req_byte_en  = s_ctrlport.req_byte_en;
  assign m_ctrlport.req_has_time = s_ctrlport.req_has_time;
  assign m_ctrlport.req_time     = s_ctrlport.req_time;

  // Registered upstream response; fields are zero whenever ack is low
  always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
    if (ctrlport_rst) begin
      resp_ack_r    <= 1'b0;
      resp_status_r <= 2'b00;
      resp_data_r   <= 32'h0000_0000;
    end else if (ack_hit_s) begin
      resp_ack_r    <= 1'b1;
      resp_status_r <= m_ctrlport.resp_status;
      resp_data_r   <= m_ctrlport.resp_data;
    end else if (timeout_hit_s) begin
      resp_ack_r    <= 1'b1;
      resp_status_r <= ST_CMDERR;
      resp_data_r   <= 32'h0000_0000;
    end else begin
      resp_ack_r    <= 1'b0;
      resp_status_r <= 2'b00;
      resp_data_r   <= 32'h0000_0000;
    end
  end

  // Saturating timeout counter and sticky dropped-request flag
  always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
    if (ctrlport_rst) begin
      timeout_count <= '0;
      req_dropped   <= 1'b0;
    end else begin
      if (timeout_hit_s && (timeout_count != {CNT_W{1'b1}})) begin
        timeout_count <= timeout_count + CNT_W'(1);
      end else begin
        timeout_count <= timeout_count;
      end
      if ((state_r == ST_WAIT) && req_s) begin
        req_dropped <= 1'b1;
      end else begin
        req_dropped <= req_dropped;
      end
    end
  end

  assign s_ctrlport.resp_ack    = resp_ack_r;
  assign s_ctrlport.resp_status = resp_status_r;
  assign s_ctrlport.resp_data   = resp_data_r;
  assign busy                   = (state_r == ST_WAIT);
endmodule

// File: tb/tb_ctrlport_if_resp_timeout.sv
// Directed bench for ctrlport_if_resp_timeout with TIMEOUT=8 (CNT_W=16 and CNT_W=2 instances).
module tb_ctrlport_if_resp_timeout;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  ctrlport_if s_bus();
  ctrlport_if m_bus();
  ctrlport_if s2_bus();
  ctrlport_if m2_bus();
  logic        busy, busy2, dropped, dropped2;
  logic [15:0] tcount;
  logic [1:0]  tcount2;

  ctrlport_if_resp_timeout #(.TIMEOUT(8), .CNT_W(16)) dut (
    .ctrlport_clk(clk), .ctrlport_rst(rst), .s_ctrlport(s_bus), .m_ctrlport(m_bus),
    .busy(busy), .timeout_count(tcount), .req_dropped(dropped)
  );
  ctrlport_if_resp_timeout #(.TIMEOUT(8), .CNT_W(2)) dut_sat (
    .ctrlport_clk(clk), .ctrlport_rst(rst), .s_ctrlport(s2_bus), .m_ctrlport(m2_bus),
    .busy(busy2), .timeout_count(tcount2), .req_dropped(dropped2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    s_bus.req_wr = 1'b0; s_bus.req_rd = 1'b0; s_bus.req_addr = 20'h0; s_bus.req_portid = 10'h0;
    s_bus.req_data = 32'h0; s_bus.req_byte_en = 4'h0; s_bus.req_has_time = 1'b0; s_bus.req_time = 64'h0;
    m_bus.resp_ack = 1'b0; m_bus.resp_status = 2'b00; m_bus.resp_data = 32'h0;
    s2_bus.req_wr = 1'b0; s2_bus.req_rd = 1'b0; s2_bus.req_addr = 20'h0; s2_bus.req_portid = 10'h0;
    s2_bus.req_data = 32'h0; s2_bus.req_byte_en = 4'h0; s2_bus.req_has_time = 1'b0; s2_bus.req_time = 64'h0;
    m2_bus.resp_ack = 1'b0; m2_bus.resp_status = 2'b00; m2_bus.resp_data = 32'h0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (s_bus.resp_ack !== 1'b0 || s_bus.resp_status !== 2'b00 || s_bus.resp_data !== 32'h0)
      $display("FAIL reset_resp: got ack=%b st=%b d=%h expected all 0", s_bus.resp_ack, s_bus.resp_status, s_bus.resp_data); else passed++;
    checks++; if (tcount !== 16'h0 || dropped !== 1'b0)
      $display("FAIL reset_status: got tc=%0d dr=%b expected 0/0", tcount, dropped); else passed++;
    checks++; if (tcount2 !== 2'd0 || busy2 !== 1'b0) $display("FAIL reset_sat: got tc=%0d busy=%b expected 0/0", tcount2, busy2); else passed++;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_ok();
    int busy_cycles = 0;
    s_bus.req_rd = 1'b1; s_bus.req_addr = 20'h00040; s_bus.req_data = 32'h1111_2222; s_bus.req_byte_en = 4'hA;
    #1;
    checks++; if (m_bus.req_rd !== 1'b1 || m_bus.req_wr !== 1'b0) $display("FAIL read_fwd: got rd=%b wr=%b expected 1/0", m_bus.req_rd, m_bus.req_wr); else passed++;
    checks++; if (m_bus.req_addr !== 20'h00040 || m_bus.req_data !== 32'h1111_2222 || m_bus.req_byte_en !== 4'hA)
      $display("FAIL read_fields: got a=%h d=%h be=%h expected 00040/11112222/a", m_bus.req_addr, m_bus.req_data, m_bus.req_byte_en); else passed++;
    for (int c = 1; c <= 4; c++) begin
      tick();
      s_bus.req_rd = 1'b0;
      if (busy === 1'b1) busy_cycles++;
      if (c < 4) begin
        checks++; if (s_bus.resp_ack !== 1'b0) $display("FAIL read_early_ack: got 1 expected 0 at cycle %0d", c); else passed++;
      end
      if (c == 3) begin
        m_bus.resp_ack = 1'b1; m_bus.resp_status = 2'b00; m_bus.resp_data = 32'hDEAD_BEEF;
      end else begin
        m_bus.resp_ack = 1'b0; m_bus.resp_data = 32'h0;
      end
    end
    checks++; if (s_bus.resp_ack !== 1'b1 || s_bus.resp_status !== 2'b00 || s_bus.resp_data !== 32'hDEAD_BEEF)
      $display("FAIL read_resp: got ack=%b st=%b d=%h expected 1/00/deadbeef", s_bus.resp_ack, s_bus.resp_status, s_bus.resp_data); else passed++;
    checks++; if (busy_cycles !== 3) $display("FAIL read_busy_len: got %0d expected 3", busy_cycles); else passed++;
    checks++; if (tcount !== 16'd0) $display("FAIL read_tcount: got %0d expected 0", tcount); else passed++;
    tick();
    checks++; if (s_bus.resp_ack !== 1'b0 || s_bus.resp_data !== 32'h0) $display("FAIL read_ack_pulse: got ack=%b d=%h expected 0/0", s_bus.resp_ack, s_bus.resp_data); else passed++;
  endtask

  task automatic test_timeout();
    s_bus.req_wr = 1'b1; s_bus.req_addr = 20'h00100; s_bus.req_data = 32'h5555_AAAA;
    for (int c = 1; c <= 8; c++) begin
      tick();
      s_bus.req_wr = 1'b0;
      m_bus.resp_data = 32'hBAD0_0000 + 32'(c);
      checks++; if (s_bus.resp_ack !== 1'b0 || busy !== 1'b1) $display("FAIL to_wait: got ack=%b busy=%b expected 0/1 at cycle %0d", s_bus.resp_ack, busy, c); else passed++;
    end
    tick();
    m_bus.resp_data = 32'h0;
    checks++; if (s_bus.resp_ack !== 1'b1 || s_bus.resp_status !== 2'b01 || s_bus.resp_data !== 32'h0)
      $display("FAIL to_resp: got ack=%b st=%b d=%h expected 1/01/0", s_bus.resp_ack, s_bus.resp_status, s_bus.resp_data); else passed++;
    checks++; if (tcount !== 16'd1 || busy !== 1'b0) $display("FAIL to_count: got tc=%0d busy=%b expected 1/0", tcount, busy); else passed++;
    for (int c = 10; c <= 14; c++) tick();
    m_bus.resp_ack = 1'b1; m_bus.resp_status = 2'b00; m_bus.resp_data = 32'h7777_7777;
    tick();
    m_bus.resp_ack = 1'b0; m_bus.resp_data = 32'h0;
    checks++; if (s_bus.resp_ack !== 1'b0 || tcount !== 16'd1) $display("FAIL late_ack: got ack=%b tc=%0d expected 0/1", s_bus.resp_ack, tcount); else passed++;
    tick();
    checks++; if (s_bus.resp_ack !== 1'b0) $display("FAIL late_ack2: got %b expected 0", s_bus.resp_ack); else passed++;
  endtask

  task automatic test_ack_on_last();
    s_bus.req_rd = 1'b1; s_bus.req_addr = 20'h00200;
    for (int c = 1; c <= 8; c++) begin
      tick();
      s_bus.req_rd = 1'b0;
      if (c == 8) begin
        m_bus.resp_ack = 1'b1; m_bus.resp_status = 2'b11; m_bus.resp_data = 32'h1234_5678;
      end
    end
    tick();
    m_bus.resp_ack = 1'b0; m_bus.resp_status = 2'b00; m_bus.resp_data = 32'h0;
    checks++; if (s_bus.resp_ack !== 1'b1 || s_bus.resp_status !== 2'b11 || s_bus.resp_data !== 32'h1234_5678)
      $display("FAIL last_resp: got ack=%b st=%b d=%h expected 1/11/12345678", s_bus.resp_ack, s_bus.resp_status, s_bus.resp_data); else passed++;
    checks++; if (tcount !== 16'd1) $display("FAIL last_tcount: got %0d expected 1", tcount); else passed++;
    tick();
    checks++; if (s_bus.resp_ack !== 1'b0) $display("FAIL last_extra_ack: got %b expected 0", s_bus.resp_ack); else passed++;
  endtask

  task automatic test_back_to_back();
    s_bus.req_rd = 1'b1; s_bus.req_addr = 20'h00300;
    tick();
    s_bus.req_rd = 1'b0;
    tick();
    s_bus.req_wr = 1'b1; s_bus.req_addr = 20'h00304;
    #1;
    checks++; if (m_bus.req_wr !== 1'b0 || m_bus.req_rd !== 1'b0) $display("FAIL drop_fwd: got wr=%b rd=%b expected 0/0", m_bus.req_wr, m_bus.req_rd); else passed++;
    tick();
    s_bus.req_wr = 1'b0;
    m_bus.resp_ack = 1'b1; m_bus.resp_status = 2'b00; m_bus.resp_data = 32'hCAFE_0001;
    checks++; if (dropped !== 1'b1) $display("FAIL drop_flag: got %b expected 1", dropped); else passed++;
    tick();
    m_bus.resp_ack = 1'b0; m_bus.resp_data = 32'h0;
    checks++; if (s_bus.resp_ack !== 1'b1 || s_bus.resp_data !== 32'hCAFE_0001)
      $display("FAIL drop_first_resp: got ack=%b d=%h expected 1/cafe0001", s_bus.resp_ack, s_bus.resp_data); else passed++;
    s_bus.req_rd = 1'b1; s_bus.req_addr = 20'h00308;
    #1;
    checks++; if (m_bus.req_rd !== 1'b1) $display("FAIL b2b_fwd: got %b expected 1", m_bus.req_rd); else passed++;
    tick();
    s_bus.req_rd = 1'b0;
    m_bus.resp_ack = 1'b1; m_bus.resp_data = 32'hCAFE_0002;
    checks++; if (s_bus.resp_ack !== 1'b0) $display("FAIL b2b_gap: got %b expected 0", s_bus.resp_ack); else passed++;
    tick();
    m_bus.resp_ack = 1'b0; m_bus.resp_data = 32'h0;
    checks++; if (s_bus.resp_ack !== 1'b1 || s_bus.resp_data !== 32'hCAFE_0002 || dropped !== 1'b1)
      $display("FAIL b2b_resp: got ack=%b d=%h dr=%b expected 1/cafe0002/1", s_bus.resp_ack, s_bus.resp_data, dropped); else passed++;
    tick();
  endtask

  task automatic test_mid_reset();
    logic seen_ack = 1'b0;
    s_bus.req_rd = 1'b1; s_bus.req_addr = 20'h00400;
    for (int c = 1; c <= 4; c++) begin
      tick();
      s_bus.req_rd = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || s_bus.resp_ack !== 1'b0 || tcount !== 16'd0 || dropped !== 1'b0)
      $display("FAIL mid_reset: got busy=%b ack=%b tc=%0d dr=%b expected 0/0/0/0", busy, s_bus.resp_ack, tcount, dropped); else passed++;
    tick(); tick();
    rst = 1'b0;
    m_bus.resp_ack = 1'b1; m_bus.resp_data = 32'h0BAD_0BAD;
    tick();
    m_bus.resp_ack = 1'b0; m_bus.resp_data = 32'h0;
    for (int c = 0; c < 10; c++) begin
      if (s_bus.resp_ack === 1'b1) seen_ack = 1'b1;
      tick();
    end
    checks++; if (seen_ack !== 1'b0) $display("FAIL post_reset_ack: got %b expected 0", seen_ack); else passed++;
    s_bus.req_rd = 1'b1; s_bus.req_addr = 20'h00404;
    tick();
    s_bus.req_rd = 1'b0;
    m_bus.resp_ack = 1'b1; m_bus.resp_status = 2'b00; m_bus.resp_data = 32'hA5A5_5A5A;
    tick();
    m_bus.resp_ack = 1'b0; m_bus.resp_data = 32'h0;
    checks++; if (s_bus.resp_ack !== 1'b1 || s_bus.resp_data !== 32'hA5A5_5A5A)
      $display("FAIL post_reset_read: got ack=%b d=%h expected 1/a5a55a5a", s_bus.resp_ack, s_bus.resp_data); else passed++;
    tick();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    for (int n = 1; n <= 5; n++) begin
      s2_bus.req_wr = 1'b1;
      for (int c = 1; c <= 9; c++) begin
        tick();
        s2_bus.req_wr = 1'b0;
      end
      exp_cnt = (n >= 3) ? 2'd3 : 2'(n);
      checks++; if (s2_bus.resp_ack !== 1'b1 || s2_bus.resp_status !== 2'b01 || tcount2 !== exp_cnt)
        $display("FAIL sat_%0d: got ack=%b st=%b tc=%0d expected 1/01/%0d", n, s2_bus.resp_ack, s2_bus.resp_status, tcount2, exp_cnt); else passed++;
    end
    tick(); tick();
    checks++; if (tcount2 !== 2'd3) $display("FAIL sat_hold: got %0d expected 3", tcount2); else passed++;
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_read_ok();
    test_timeout();
    test_ack_on_last();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
